// File: rtl/br_adj_pkg.sv
// br_adj_pkg: shared FSM states and BMP header layout for the brightness adjuster
package br_adj_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PIXEL, DONE, ERR} state_t;
  localparam int FS_IDX = 2;
  localparam int OFF_IDX = 10;
  localparam int W_IDX = 18;
  localparam int H_IDX = 22;
  localparam int HDR_MIN_BYTES = 26;
  localparam int PIX_W = 8;
endpackage

// File: rtl/br_sat_add.sv
// br_sat_add: unsigned pixel adder that clamps at full scale instead of wrapping
module br_sat_add
  import br_adj_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] y
);
  logic [PIX_W:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
  assign y = sum[PIX_W] ? '1 : sum[PIX_W-1:0];
endmodule

// File: rtl/bmp_br_adj_ctrl.sv
// bmp_br_adj_ctrl: streams a BMP file through, capturing header fields and brightening pixels
module bmp_br_adj_ctrl #(
  parameter int MAX_FILE_BYTES = 500001,
  parameter int HDR_MIN_BYTES = br_adj_pkg::HDR_MIN_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  br_offset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        hdr_err,
  output logic [31:0] bmp_width,
  output logic [31:0] bmp_height,
  output logic [31:0] data_offset,
  output logic [31:0] file_size
);
  import br_adj_pkg::*;
  state_t state;
  logic [31:0] idx;
  logic [31:0] off_n;
  logic [7:0] br_q;
  logic [7:0] sat;
  logic in_x;
  logic hdr_bad;
  function automatic logic in_fld(logic [31:0] i, int base);
    return i >= 32'(base) && i < 32'(base + 4);
  endfunction
  function automatic logic [4:0] lane(logic [31:0] i, int base);
    return {2'(i - 32'(base)), 3'b000};
  endfunction
  br_sat_add u_add (.a(s_data), .b(br_q), .y(sat));
  assign busy = state == HEADER || state == PIXEL;
  assign s_ready = busy && (!m_valid || m_ready);
  assign in_x = s_valid && s_ready;
  // data_offset is only complete once its top byte (idx 13) arrives, so check against the incoming byte
  assign off_n = {s_data, data_offset[23:0]};
  assign hdr_bad = off_n < 32'(HDR_MIN_BYTES) || file_size <= off_n ||
                   file_size > 32'(MAX_FILE_BYTES);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      br_q <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      done <= 1'b0;
      hdr_err <= 1'b0;
      file_size <= '0;
      data_offset <= '0;
      bmp_width <= '0;
      bmp_height <= '0;
    end else begin
      done <= 1'b0;
      if (in_x) begin
        m_data <= state == PIXEL ? sat : s_data;
        m_valid <= 1'b1;
        idx <= idx + 32'd1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      case (state)
        IDLE, ERR: if (start) begin
          state <= HEADER;
          idx <= '0;
          hdr_err <= 1'b0;
          br_q <= br_offset;
          file_size <= '0;
          data_offset <= '0;
          bmp_width <= '0;
          bmp_height <= '0;
        end
        HEADER: if (in_x) begin
          if (in_fld(idx, FS_IDX)) file_size[lane(idx, FS_IDX) +: 8] <= s_data;
          if (in_fld(idx, OFF_IDX)) data_offset[lane(idx, OFF_IDX) +: 8] <= s_data;
          if (in_fld(idx, W_IDX)) bmp_width[lane(idx, W_IDX) +: 8] <= s_data;
          if (in_fld(idx, H_IDX)) bmp_height[lane(idx, H_IDX) +: 8] <= s_data;
          if (idx == 32'(OFF_IDX + 3) && hdr_bad) begin
            state <= ERR;
            hdr_err <= 1'b1;
          end else if (idx >= 32'(H_IDX + 3) && idx == data_offset - 32'd1) begin
            state <= PIXEL;
          end
        end
        PIXEL: if (in_x && idx == file_size - 32'd1) begin
          state <= DONE;
          done <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bmp_br_adj_ctrl.sv
// tb_bmp_br_adj_ctrl: directed frames with hand-built headers checked byte-for-byte against a saturating model
module tb_bmp_br_adj_ctrl;
  logic clk = 1'b0;
  logic rst, start, s_valid, s_ready, m_valid, m_ready, busy, done, hdr_err;
  logic [7:0] br_offset, s_data, m_data;
  logic [31:0] bmp_width, bmp_height, data_offset, file_size;
  int vectors = 0;
  int errors = 0;
  logic [7:0] frm[$];
  logic [7:0] expq[$];
  int n_out, n_done, n_extra;

  always #5 clk = ~clk;

  bmp_br_adj_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .br_offset(br_offset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .hdr_err(hdr_err),
    .bmp_width(bmp_width), .bmp_height(bmp_height),
    .data_offset(data_offset), .file_size(file_size)
  );

  // mode < 256: constant pixel; 256: cycle 195,196,255,0; 257: index-derived pattern
  function automatic void build(int fsz, int dofs, int w, int h, int len, int boff, int mode);
    logic [7:0] cyc [4] = '{8'd195, 8'd196, 8'd255, 8'd0};
    frm.delete();
    expq.delete();
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      int s;
      if (i < dofs) begin
        b = 8'(i * 29 + 3);
        if (i == 0) b = 8'h42;
        else if (i == 1) b = 8'h4D;
        else if (i >= 2 && i < 6) b = 8'(fsz >> (8 * (i - 2)));
        else if (i >= 10 && i < 14) b = 8'(dofs >> (8 * (i - 10)));
        else if (i >= 18 && i < 22) b = 8'(w >> (8 * (i - 18)));
        else if (i >= 22 && i < 26) b = 8'(h >> (8 * (i - 22)));
        frm.push_back(b);
        expq.push_back(b);
      end else begin
        b = mode < 256 ? 8'(mode) : mode == 256 ? cyc[(i - dofs) % 4] : 8'(i * 37 + 11);
        s = int'(b) + boff;
        frm.push_back(b);
        expq.push_back(s > 255 ? 8'hFF : 8'(s));
      end
    end
  endfunction

  task automatic run_stream(input logic [7:0] boff, input int n_exp, input int gap, input int bp,
                            input int pulse_at);
    int in_n = 0;
    int cyc = 0;
    bit pulsed = 0;
    n_out = 0;
    n_done = 0;
    n_extra = 0;
    @(posedge clk); #1;
    start = 1'b1;
    br_offset = boff;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    br_offset = 8'h00;
    while (n_out < n_exp && cyc < 40000) begin
      s_valid = in_n < frm.size() && $urandom_range(99) >= gap;
      s_data = in_n < frm.size() ? frm[in_n] : 8'h00;
      m_ready = $urandom_range(99) >= bp;
      if (!pulsed && pulse_at >= 0 && in_n == pulse_at) begin
        start = 1'b1;
        br_offset = 8'hC8;
        pulsed = 1;
      end
      @(negedge clk);
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== expq[n_out]) begin
          errors++;
          $display("FAIL byte[%0d]: got %h expected %h", n_out, m_data, expq[n_out]);
        end
        n_out++;
      end
      if (s_valid && s_ready) in_n++;
      if (done) n_done++;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    vectors++;
    if (cyc >= 40000) begin
      errors++;
      $display("FAIL stream_timeout: got %0d bytes expected %0d", n_out, n_exp);
    end
    // keep offering input: nothing more may be accepted once the frame has ended or failed
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      if (m_valid) n_extra++;
      if (done) n_done++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    br_offset = 8'h00;
    s_data = 8'h00;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m_valid, done, busy, hdr_err, s_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {m_valid, done, busy, hdr_err, s_ready});
    end
    vectors++;
    if (m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_m_data: got %h expected 00", m_data);
    end
    vectors++;
    if ({bmp_width, bmp_height, data_offset, file_size} !== 128'b0) begin
      errors++;
      $display("FAIL reset_fields: got %h %h %h %h expected all 0", bmp_width, bmp_height,
               data_offset, file_size);
    end
  endtask

  task automatic test_basic();
    build(454, 54, 20, 20, 454, 60, 8'h64);
    run_stream(8'd60, 454, 0, 0, -1);
    vectors++;
    if (n_done !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", n_done); end
    vectors++;
    if (n_extra !== 0) begin errors++; $display("FAIL basic_extra: got %0d expected 0", n_extra); end
    vectors++;
    if ({file_size, data_offset, bmp_width, bmp_height} !== {32'd454, 32'd54, 32'd20, 32'd20}) begin
      errors++;
      $display("FAIL basic_fields: got %0d %0d %0d %0d expected 454 54 20 20", file_size, data_offset,
               bmp_width, bmp_height);
    end
    vectors++;
    if ({busy, hdr_err} !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b hdr_err=%b expected 0 0", busy, hdr_err);
    end
  endtask

  task automatic test_saturate();
    build(34, 26, 2, 4, 34, 60, 256);
    run_stream(8'd60, 34, 0, 0, -1);
    vectors++;
    if (n_done !== 1) begin errors++; $display("FAIL sat_done: got %0d expected 1", n_done); end
    build(27, 26, 1, 1, 27, 0, 255);
    run_stream(8'd0, 27, 0, 0, -1);
    vectors++;
    if (n_done !== 1) begin errors++; $display("FAIL one_pixel_done: got %0d expected 1", n_done); end
    vectors++;
    if (n_extra !== 0) begin errors++; $display("FAIL one_pixel_extra: got %0d expected 0", n_extra); end
  endtask

  task automatic test_hdr_err();
    int fs [3] = '{100, 54, 600000};
    int off [3] = '{20, 54, 54};
    for (int k = 0; k < 3; k++) begin
      build(fs[k], off[k], 1, 1, 100, 0, 0);
      run_stream(8'd0, 14, 0, 0, -1);
      vectors++;
      if (n_extra !== 0) begin errors++; $display("FAIL err%0d_extra: got %0d expected 0", k, n_extra); end
      vectors++;
      if (n_done !== 0) begin errors++; $display("FAIL err%0d_done: got %0d expected 0", k, n_done); end
      vectors++;
      if ({hdr_err, s_ready, busy} !== 3'b100) begin
        errors++;
        $display("FAIL err%0d_state: got hdr_err,s_ready,busy=%b expected 100", k, {hdr_err, s_ready, busy});
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if ({hdr_err, busy} !== 2'b01) begin
        errors++;
        $display("FAIL err%0d_restart: got hdr_err,busy=%b expected 01", k, {hdr_err, busy});
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    build(1478, 1078, 20, 20, 1478, 90, 257);
    run_stream(8'd90, 1478, 30, 40, -1);
    vectors++;
    if (n_done !== 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", n_done); end
    vectors++;
    if (n_extra !== 0) begin errors++; $display("FAIL bp_extra: got %0d expected 0", n_extra); end
  endtask

  task automatic test_start_in_pixel();
    build(454, 54, 20, 20, 454, 25, 257);
    run_stream(8'd25, 454, 10, 10, 200);
    vectors++;
    if (n_done !== 1) begin errors++; $display("FAIL pix_start_done: got %0d expected 1", n_done); end
    vectors++;
    if (n_extra !== 0) begin errors++; $display("FAIL pix_start_extra: got %0d expected 0", n_extra); end
  endtask

  task automatic test_rst_mid();
    int in_n = 0;
    int cyc = 0;
    int dn = 0;
    build(6000, 54, 100, 59, 6000, 60, 257);
    @(posedge clk); #1;
    start = 1'b1;
    br_offset = 8'd60;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (in_n < 5000 && cyc < 20000) begin
      s_valid = 1'b1;
      s_data = frm[in_n];
      @(negedge clk);
      if (s_valid && s_ready) in_n++;
      if (done) dn++;
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (in_n !== 5000) begin errors++; $display("FAIL rst_mid_feed: got %0d expected 5000", in_n); end
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({m_valid, done, busy, hdr_err, s_ready, m_data} !== 13'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b expected all 0", {m_valid, done, busy, hdr_err, s_ready, m_data});
    end
    vectors++;
    if ({bmp_width, bmp_height, data_offset, file_size} !== 128'b0) begin
      errors++;
      $display("FAIL rst_mid_fields: got %h %h %h %h expected all 0", bmp_width, bmp_height,
               data_offset, file_size);
    end
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || m_valid || s_ready) dn++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    vectors++;
    if (dn !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d events expected 0", dn); end
    build(454, 54, 20, 20, 454, 60, 257);
    run_stream(8'd60, 454, 0, 0, -1);
    vectors++;
    if (n_done !== 1) begin errors++; $display("FAIL rst_mid_next_done: got %0d expected 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_hdr_err();
    test_backpressure();
    test_start_in_pixel();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
